// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, reads the combinational ROM,
// and buffers fetched words in a small prefetch FIFO ahead of decode.
module inst_fetch_ctrl #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fetch_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  output logic              misalign_err,
  output logic [31:0]       fetch_pc
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misalign_q, misalign_d;
  logic [31:0]      pc_mem_q   [DEPTH];
  logic [31:0]      pc_mem_d   [DEPTH];
  logic [31:0]      inst_mem_q [DEPTH];
  logic [31:0]      inst_mem_d [DEPTH];
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // Push looks at the starting count only, so a full FIFO skips a cycle even if it pops.
  assign push = fetch_en && !redirect_valid && (count_q < CNT_W'(DEPTH));
  assign pop  = (count_q != '0) && out_ready && !redirect_valid;

  always_comb begin
    pc_d       = pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    misalign_d = misalign_q;
    pc_mem_d   = pc_mem_q;
    inst_mem_d = inst_mem_q;
    if (redirect_valid) begin
      pc_d       = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      misalign_d = misalign_q | (redirect_pc[1:0] != 2'b00);
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = pc_q;
        inst_mem_d[wr_ptr_q] = rom_inst;
        wr_ptr_d             = ptr_inc(wr_ptr_q);
        pc_d                 = pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc_q       <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      misalign_q <= misalign_d;
      pc_mem_q   <= pc_mem_d;
      inst_mem_q <= inst_mem_d;
    end
  end

  // Upper PC bits are ignored for the ROM, so addresses alias across the ROM size.
  assign rom_addr     = pc_q[ADDR_W+1:2];
  assign fetch_pc     = pc_q;
  assign misalign_err = misalign_q;
  assign out_valid    = (count_q != '0);
  assign out_inst     = out_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign out_pc       = out_valid ? pc_mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Randomised scoreboard bench for inst_fetch_ctrl, checked against a queue-based
// model of the fetch pipeline and a bench-owned ROM image.
module tb_inst_fetch_ctrl;

  localparam int DEPTH  = 2;
  localparam int ADDR_W = 5;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  logic              clk;
  logic              resetn;
  logic              fetch_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [31:0]       rom_inst;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [31:0]       out_pc;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              misalign_err;
  logic [31:0]       fetch_pc;

  logic [31:0] rom [32];
  entry_t      exp_q[$];
  logic [31:0] m_pc;
  logic        m_err;
  int          m_size;
  int          checks;
  int          errors;

  inst_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(32'h0), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .fetch_en       (fetch_en),
    .rom_addr       (rom_addr),
    .rom_inst       (rom_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .misalign_err   (misalign_err),
    .fetch_pc       (fetch_pc)
  );

  assign rom_inst = rom[rom_addr];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model: the FIFO is a plain queue, updated from the inputs seen at each edge.
  initial begin
    m_pc  = 32'h0;
    m_err = 1'b0;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        m_pc  = 32'h0;
        m_err = 1'b0;
      end else if (redirect_valid) begin
        exp_q.delete();
        m_pc = redirect_pc & 32'hFFFF_FFFC;
        if (redirect_pc[1:0] != 2'b00) m_err = 1'b1;
      end else begin
        m_size = exp_q.size();
        if (out_ready && m_size > 0) void'(exp_q.pop_front());
        if (fetch_en && m_size < DEPTH) begin
          exp_q.push_back('{pc: m_pc, inst: rom[m_pc[6:2]]});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Monitor: compares the presented head and status against the model every cycle.
  initial begin
    forever begin
      @(negedge clk);
      check_output("out_valid", out_valid, exp_q.size() != 0);
      check_output("fetch_pc", fetch_pc, m_pc);
      check_output("rom_addr", rom_addr, m_pc[6:2]);
      check_output("misalign_err", misalign_err, m_err);
      if (exp_q.size() != 0) begin
        if (out_ready && !redirect_valid) begin
          check_output("accepted_pc", out_pc, exp_q[0].pc);
          check_output("accepted_inst", out_inst, exp_q[0].inst);
        end else begin
          check_output("head_pc", out_pc, exp_q[0].pc);
          check_output("head_inst", out_inst, exp_q[0].inst);
        end
      end else begin
        check_output("empty_pc", out_pc, 32'h0);
        check_output("empty_inst", out_inst, 32'h0);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) begin
      rom[i] = (i < 24) ? (32'hA500_0000 | 32'(i)) : 32'h0;
    end
    rom[0]  = 32'h2401_0001;
    rom[1]  = 32'h0001_1100;
    rom[2]  = 32'h0041_1821;
    rom[13] = 32'h8C2A_0013;

    resetn         = 1'b0;
    fetch_en       = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    apply_stimulus(3);

    fetch_en  = 1'b1;
    out_ready = 1'b1;
    resetn    = 1'b1;
    apply_stimulus(1);
    check_output("first_valid", out_valid, 1'b1);
    check_output("first_pc", out_pc, 32'h0);
    check_output("first_inst", out_inst, 32'h2401_0001);
    apply_stimulus(1);
    check_output("second_pc", out_pc, 32'h4);
    check_output("second_inst", out_inst, 32'h0001_1100);
    apply_stimulus(1);
    check_output("third_pc", out_pc, 32'h8);
    check_output("third_inst", out_inst, 32'h0041_1821);
    apply_stimulus(5);

    resetn = 1'b0;
    apply_stimulus(2);
    out_ready = 1'b0;
    resetn    = 1'b1;
    apply_stimulus(6);
    check_output("bp_fetch_pc", fetch_pc, 32'h8);
    check_output("bp_rom_addr", rom_addr, 32'h2);
    out_ready = 1'b1;
    apply_stimulus(6);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h2C;
    out_ready      = 1'b0;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    apply_stimulus(3);
    check_output("held_pc", out_pc, 32'h2C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h34;
    out_ready      = 1'b1;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    check_output("flush_gap", out_valid, 1'b0);
    check_output("flush_fetch_pc", fetch_pc, 32'h34);
    apply_stimulus(1);
    check_output("after_flush_pc", out_pc, 32'h34);
    check_output("after_flush_inst", out_inst, 32'h8C2A_0013);
    apply_stimulus(9);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    apply_stimulus(4);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h7C;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    apply_stimulus(2);
    check_output("wrap_out_pc", out_pc, 32'h80);
    check_output("wrap_out_inst", out_inst, rom[0]);
    apply_stimulus(3);

    redirect_valid = 1'b1;
    redirect_pc    = 32'h35;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    check_output("misalign_pc", fetch_pc, 32'h34);
    check_output("misalign_set", misalign_err, 1'b1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    apply_stimulus(1);
    redirect_valid = 1'b0;
    check_output("misalign_sticky", misalign_err, 1'b1);
    apply_stimulus(3);

    for (int i = 0; i < 1500; i++) begin
      fetch_en       = ($urandom_range(0, 9) < 8);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 160));
      apply_stimulus(1);
    end
    redirect_valid = 1'b0;
    fetch_en       = 1'b1;
    out_ready      = 1'b1;
    apply_stimulus(4);

    resetn = 1'b0;
    #1;
    check_output("async_reset_valid", out_valid, 1'b0);
    check_output("async_reset_pc", fetch_pc, 32'h0);
    check_output("async_reset_err", misalign_err, 1'b0);
    apply_stimulus(2);
    resetn = 1'b1;
    apply_stimulus(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
